// File: rtl/cmd_stream_tx_pkg.sv
// Shared widths and serializer state encoding for cmd_stream_tx.
// Defining CMD_STREAM_TX_CSUM_EN adds the CSUM state.
package cmd_stream_tx_pkg;
    localparam int CMD_W  = 32;
    localparam int AXIS_W = 16;

`ifdef CMD_STREAM_TX_CSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_CSUM = 2'd3
    } tx_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } tx_state_e;
`endif
endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra bit to tell full from empty.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/cmd_stream_tx.sv
// Command FIFO feeding a 32->16 bit stream serializer with packet counting.
// Defining CMD_STREAM_TX_CSUM_EN appends an XOR checksum beat to every packet.
module cmd_stream_tx
    import cmd_stream_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CMD_W-1:0]  cmd_data,
    input  logic              cmd_last,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [AXIS_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic [15:0]       pkt_count,
    output logic [1:0]        o_dbg_state
);
    // Both ports: a transfer occurs on a rising edge with valid && ready; once
    // valid is high, data and last hold until that transfer completes.
    logic [CMD_W:0]    w_fifo_rdata;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_hs;
    logic              w_to_csum;
    logic              r_started;
    tx_state_e         r_state;
    logic [AXIS_W-1:0] r_lo;
    logic              r_last;
    logic [AXIS_W-1:0] r_tdata;
    logic              r_tvalid;
    logic              r_tlast;
    logic [15:0]       r_pkt_count;

    assign w_push = cmd_valid && cmd_ready;
    assign w_hs   = r_tvalid && m_axis_tready;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({cmd_last, cmd_data}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef CMD_STREAM_TX_CSUM_EN
    logic [AXIS_W-1:0] r_acc;

    assign w_to_csum = (r_state == ST_LO) && r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_hs) begin
            r_acc <= (r_state == ST_CSUM) ? '0 : (r_acc ^ r_tdata);
        end
    end
`else
    assign w_to_csum = 1'b0;
`endif

    // Pop only when the serializer is about to load a new HI beat.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = !w_empty;
            ST_HI:   w_pop = 1'b0;
            default: w_pop = w_hs && !w_empty && !w_to_csum;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started   <= 1'b0;
            r_state     <= ST_IDLE;
            r_lo        <= '0;
            r_last      <= 1'b0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_started <= 1'b1;
            if (w_hs && r_tlast) r_pkt_count <= r_pkt_count + 16'd1;
            case (r_state)
                ST_HI: begin
                    if (w_hs) begin
                        r_state <= ST_LO;
                        r_tdata <= r_lo;
`ifdef CMD_STREAM_TX_CSUM_EN
                        r_tlast <= 1'b0;
`else
                        r_tlast <= r_last;
`endif
                    end
                end
                default: begin
                    if (r_state == ST_IDLE || w_hs) begin
`ifdef CMD_STREAM_TX_CSUM_EN
                        if (w_to_csum) begin
                            r_state <= ST_CSUM;
                            r_tdata <= r_acc ^ r_tdata;
                            r_tlast <= 1'b1;
                        end else
`endif
                        if (w_pop) begin
                            r_state  <= ST_HI;
                            r_tvalid <= 1'b1;
                            r_tdata  <= w_fifo_rdata[CMD_W-1:AXIS_W];
                            r_lo     <= w_fifo_rdata[AXIS_W-1:0];
                            r_last   <= w_fifo_rdata[CMD_W];
                            r_tlast  <= 1'b0;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_tvalid <= 1'b0;
                            r_tdata  <= '0;
                            r_tlast  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_ready     = r_started && !w_full;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = !w_empty || (r_state != ST_IDLE);
    assign pkt_count     = r_pkt_count;
    assign o_dbg_state   = r_state;
endmodule
